// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with SUMP command assembler.
// Receives bytes from the host link by sampling each bit at its midpoint,
// then groups them into 1-byte short commands or 5-byte long commands
// (opcode + 32-bit little-endian data). Each completed command is presented
// with a one-cycle execute strobe.
// Optional build macro: UART_RX_TIMEOUT_EN drops a partial long command
// after 16 idle bit times.
module uart_rx_cmd #(
    parameter int FREQ      = 100000000,
    parameter int BAUDRATE  = 115200,
    parameter int BITLENGTH = FREQ / BAUDRATE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        framing_error,
    output logic [7:0]  opcode,
    output logic [31:0] opdata,
    output logic        execute
);

    localparam logic [15:0] HALF_BIT = 16'(BITLENGTH / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(BITLENGTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Synchronizer and edge-detect flops (idle line is high)
    logic sync1_q, rx_s_q, rx_d_q;

    // Bit-level receiver state
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte_q;
    logic        rx_byte_valid_q;
    logic        framing_error_q;

    // Command assembler state
    logic [2:0]  count_q,     count_d;
    logic [7:0]  pend_op_q,   pend_op_d;
    logic [23:0] pend_data_q, pend_data_d;
    logic [7:0]  opcode_q,    opcode_d;
    logic [31:0] opdata_q,    opdata_d;
    logic        execute_q,   execute_d;

    // Stop-bit sample outcomes, evaluated on the sampling clock edge
    logic byte_ok, byte_bad;
    assign byte_ok  = (state_q == STOP) && (cnt_q == 16'd0) &&  rx_s_q;
    assign byte_bad = (state_q == STOP) && (cnt_q == 16'd0) && !rx_s_q;

    // Bring the asynchronous line into the clock domain; rx_d is one clock older
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // Bit FSM: find the start edge, sample every bit at mid-bit, check stop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= 16'd0;
            idx_q           <= 3'd0;
            shift_q         <= 8'd0;
            rx_byte_q       <= 8'd0;
            rx_byte_valid_q <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            rx_byte_valid_q <= 1'b0;
            framing_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only a high-to-low transition starts a byte, so a held
                    // break condition is ignored.
                    if (rx_d_q && !rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_BIT;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            cnt_q   <= FULL_BIT;
                            idx_q   <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= FULL_BIT;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (rx_s_q) begin
                            rx_byte_q       <= shift_q;
                            rx_byte_valid_q <= 1'b1;
                        end else begin
                            framing_error_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LIM = 24'(16 * BITLENGTH);
    logic [23:0] idle_cnt_q, idle_cnt_d;
    logic        timeout_hit;
    assign timeout_hit = (state_q == IDLE) && (count_q != 3'd0) &&
                         (idle_cnt_q == TIMEOUT_LIM - 24'd1);

    // Idle time between bytes of a partial long command
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (byte_ok || byte_bad || count_q == 3'd0 || timeout_hit) begin
            idle_cnt_d = 24'd0;
        end else if (state_q == IDLE) begin
            idle_cnt_d = idle_cnt_q + 24'd1;
        end
    end

    // Idle counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= 24'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    // Command assembly: decided on the stop-bit sample edge so execute lines
    // up with rx_byte_valid of the final byte
    always_comb begin
        count_d     = count_q;
        pend_op_d   = pend_op_q;
        pend_data_d = pend_data_q;
        opcode_d    = opcode_q;
        opdata_d    = opdata_q;
        execute_d   = 1'b0;
        if (byte_ok) begin
            if (count_q == 3'd0) begin
                pend_op_d = shift_q;
                if (!shift_q[7]) begin
                    opcode_d  = shift_q;
                    opdata_d  = 32'd0;
                    execute_d = 1'b1;
                end else begin
                    count_d = 3'd1;
                end
            end else begin
                case (count_q)
                    3'd1:    pend_data_d[7:0]   = shift_q;
                    3'd2:    pend_data_d[15:8]  = shift_q;
                    3'd3:    pend_data_d[23:16] = shift_q;
                    default: pend_data_d        = pend_data_q;
                endcase
                if (count_q == 3'd4) begin
                    opcode_d  = pend_op_q;
                    opdata_d  = {shift_q, pend_data_q};
                    execute_d = 1'b1;
                    count_d   = 3'd0;
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
        end else if (byte_bad || timeout_hit) begin
            count_d = 3'd0;
        end
    end

    // Command assembler registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= 3'd0;
            pend_op_q   <= 8'd0;
            pend_data_q <= 24'd0;
            opcode_q    <= 8'd0;
            opdata_q    <= 32'd0;
            execute_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            pend_op_q   <= pend_op_d;
            pend_data_q <= pend_data_d;
            opcode_q    <= opcode_d;
            opdata_q    <= opdata_d;
            execute_q   <= execute_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign framing_error = framing_error_q;
    assign opcode        = opcode_q;
    assign opdata        = opdata_q;
    assign execute       = execute_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Scoreboard bench for uart_rx_cmd at 16 clocks per bit.
module tb_uart_rx_cmd;

    localparam int BIT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        framing_error;
    logic [7:0]  opcode;
    logic [31:0] opdata;
    logic        execute;

    uart_rx_cmd #(.FREQ(1600000), .BAUDRATE(100000)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .framing_error (framing_error),
        .opcode        (opcode),
        .opdata        (opdata),
        .execute       (execute)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_bytes[$];
    logic [39:0] exp_cmds[$];
    int          exp_fe = 0;
    logic [39:0] held_cmd = 40'd0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every DUT pulse against the expected queues
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_byte_valid) begin
                if (exp_bytes.size() == 0) begin
                    chk("spurious_rx_byte_valid", {39'd0, rx_byte_valid}, 40'd0);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    chk("rx_byte", {32'd0, rx_byte}, {32'd0, eb});
                end
            end
            if (execute) begin
                chk("execute_with_valid", {39'd0, rx_byte_valid}, 40'd1);
                if (exp_cmds.size() == 0) begin
                    chk("spurious_execute", {39'd0, execute}, 40'd0);
                end else begin
                    logic [39:0] ec;
                    ec = exp_cmds.pop_front();
                    chk("opcode_opdata", {opcode, opdata}, ec);
                    held_cmd = ec;
                end
            end else begin
                chk("cmd_hold", {opcode, opdata}, held_cmd);
            end
            if (framing_error) begin
                chk("framing_error_expected", {39'd0, framing_error}, {39'd0, exp_fe > 0});
                if (exp_fe > 0) exp_fe--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clock);
        end
        uart_rx = stop_ok;
        repeat (BIT) @(negedge clock);
        uart_rx = 1'b1;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_byte"},       {32'd0, rx_byte},       40'd0);
        chk({tag, "_rx_byte_valid"}, {39'd0, rx_byte_valid}, 40'd0);
        chk({tag, "_framing_error"}, {39'd0, framing_error}, 40'd0);
        chk({tag, "_opcode"},        {32'd0, opcode},        40'd0);
        chk({tag, "_opdata"},        {8'd0, opdata},         40'd0);
        chk({tag, "_execute"},       {39'd0, execute},       40'd0);
    endtask

    initial begin
        logic [7:0] a5;
        // Reset state
        repeat (5) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clock);

        // Short command 0x01
        exp_bytes.push_back(8'h01);
        exp_cmds.push_back({8'h01, 32'h0});
        send_byte(8'h01, 1'b1);

        // Long command C0 11 22 33 44
        exp_bytes.push_back(8'hC0); exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_cmds.push_back({8'hC0, 32'h44332211});
        send_byte(8'hC0, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);

        // 3-clock glitch, then a normal byte must still be received
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        repeat (3 * BIT) @(negedge clock);
        exp_bytes.push_back(8'h05);
        exp_cmds.push_back({8'h05, 32'h0});
        send_byte(8'h05, 1'b1);

        // Framing error aborts a partial long command
        exp_bytes.push_back(8'hC0); exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h02);
        exp_fe++;
        exp_cmds.push_back({8'h02, 32'h0});
        send_byte(8'hC0, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h02, 1'b1);

        // Reset in the middle of 0xA5's data bits
        a5 = 8'hA5;
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            uart_rx = a5[i];
            repeat (BIT) @(negedge clock);
        end
        reset = 1'b1;
        held_cmd = 40'd0;
        #1;
        check_reset_outputs("midbyte_reset");
        uart_rx = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("held_reset");
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clock);
        exp_bytes.push_back(8'h03);
        exp_cmds.push_back({8'h03, 32'h0});
        send_byte(8'h03, 1'b1);

        // Partial long command followed by a long idle gap
        exp_bytes.push_back(8'h80); exp_bytes.push_back(8'hAA);
        send_byte(8'h80, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (20 * BIT) @(negedge clock);
        exp_bytes.push_back(8'h04);
`ifdef UART_RX_TIMEOUT_EN
        exp_cmds.push_back({8'h04, 32'h0});
`endif
        send_byte(8'h04, 1'b1);

        // Everything expected must have been seen
        repeat (2 * BIT) @(negedge clock);
        chk("bytes_outstanding", 40'(exp_bytes.size()), 40'd0);
        chk("cmds_outstanding",  40'(exp_cmds.size()),  40'd0);
        chk("fe_outstanding",    40'(exp_fe),           40'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
